// File: rtl/cwe1280_access_initiator.sv
// ---------------------------------------------------------------------------
// cwe1280_access_initiator
//
// Requester side of a user-ID-gated data register. A write command (user ID
// plus data byte) is accepted over a valid/ready port and driven onto the
// target's usr_id/data_in bus. The bus is held for SETTLE cycles, then the
// target's data_out is sampled. The response says whether the write landed
// (applied), whether the register moved (changed), and whether a
// non-privileged ID managed to move it (violation).
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake; one command in flight at a time
//   cmd_usr_id/data   requesting user ID and data byte
//   tgt_usr_id/data   driven to the target; IDLE_ID when no command is active
//   tgt_data_out      target register readback
//   rsp_valid/ready   response handshake
//   rsp_applied       readback == commanded data
//   rsp_changed       readback != value seen at command accept
//   rsp_violation     non-privileged ID changed the target
//   rsp_readback      sampled target data_out
//   grant/deny/viol_cnt  saturating response counters
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module cwe1280_access_initiator #(
    parameter logic [2:0] PRIV_ID = 3'h4,
    parameter logic [2:0] IDLE_ID = 3'h0,
    parameter int         SETTLE  = 2,
    parameter int         CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_usr_id,
    input  logic [7:0]       cmd_data,
    output logic [2:0]       tgt_usr_id,
    output logic [7:0]       tgt_data,
    input  logic [7:0]       tgt_data_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_applied,
    output logic             rsp_changed,
    output logic             rsp_violation,
    output logic [7:0]       rsp_readback,
    output logic [CNT_W-1:0] grant_cnt,
    output logic [CNT_W-1:0] deny_cnt,
    output logic [CNT_W-1:0] viol_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic       cmd_ready_reg, cmd_ready_next;
    logic [2:0] usr_id_reg, usr_id_next;       // captured command ID
    logic [2:0] tgt_usr_id_reg, tgt_usr_id_next;
    logic [7:0] tgt_data_reg, tgt_data_next;   // doubles as the captured data
    logic [7:0] pre_reg, pre_next;             // target value at accept
    logic [3:0] settle_reg, settle_next;
    logic       rsp_valid_reg, rsp_valid_next;
    logic       rsp_applied_reg, rsp_applied_next;
    logic       rsp_changed_reg, rsp_changed_next;
    logic       rsp_violation_reg, rsp_violation_next;
    logic [7:0] rsp_readback_reg, rsp_readback_next;

    // Counter increment requests: [0] grant, [1] deny, [2] violation
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [3];

    // Sample-edge classification, from the live readback
    logic sample_applied, sample_changed;
    assign sample_applied = (tgt_data_out == tgt_data_reg);
    assign sample_changed = (tgt_data_out != pre_reg);

    always_comb begin
        state_next         = state_reg;
        cmd_ready_next     = cmd_ready_reg;
        usr_id_next        = usr_id_reg;
        tgt_usr_id_next    = tgt_usr_id_reg;
        tgt_data_next      = tgt_data_reg;
        pre_next           = pre_reg;
        settle_next        = settle_reg;
        rsp_valid_next     = rsp_valid_reg;
        rsp_applied_next   = rsp_applied_reg;
        rsp_changed_next   = rsp_changed_reg;
        rsp_violation_next = rsp_violation_reg;
        rsp_readback_next  = rsp_readback_reg;
        cnt_inc            = 3'b000;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    usr_id_next     = cmd_usr_id;
                    tgt_usr_id_next = cmd_usr_id;
                    tgt_data_next   = cmd_data;
                    pre_next        = tgt_data_out;
                    settle_next     = 4'(SETTLE - 1);
                    cmd_ready_next  = 1'b0;
                    state_next      = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (settle_reg == 4'd0) begin
                    rsp_readback_next  = tgt_data_out;
                    rsp_applied_next   = sample_applied;
                    rsp_changed_next   = sample_changed;
                    rsp_violation_next = (usr_id_reg != PRIV_ID) && sample_changed;
                    rsp_valid_next     = 1'b1;
                    // Drop privilege right away; data stays on the bus.
                    tgt_usr_id_next    = IDLE_ID;
                    cnt_inc[0]         = (usr_id_reg == PRIV_ID);
                    cnt_inc[1]         = (usr_id_reg != PRIV_ID);
                    cnt_inc[2]         = (usr_id_reg != PRIV_ID) && sample_changed;
                    state_next         = ST_RESP;
                end else begin
                    settle_next = settle_reg - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    cmd_ready_next = 1'b1;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                state_next      = ST_IDLE;
                cmd_ready_next  = 1'b1;
                tgt_usr_id_next = IDLE_ID;
                rsp_valid_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            cmd_ready_reg     <= 1'b1;
            usr_id_reg        <= 3'h0;
            tgt_usr_id_reg    <= IDLE_ID;
            tgt_data_reg      <= 8'h00;
            pre_reg           <= 8'h00;
            settle_reg        <= 4'd0;
            rsp_valid_reg     <= 1'b0;
            rsp_applied_reg   <= 1'b0;
            rsp_changed_reg   <= 1'b0;
            rsp_violation_reg <= 1'b0;
            rsp_readback_reg  <= 8'h00;
        end else begin
            state_reg         <= state_next;
            cmd_ready_reg     <= cmd_ready_next;
            usr_id_reg        <= usr_id_next;
            tgt_usr_id_reg    <= tgt_usr_id_next;
            tgt_data_reg      <= tgt_data_next;
            pre_reg           <= pre_next;
            settle_reg        <= settle_next;
            rsp_valid_reg     <= rsp_valid_next;
            rsp_applied_reg   <= rsp_applied_next;
            rsp_changed_reg   <= rsp_changed_next;
            rsp_violation_reg <= rsp_violation_next;
            rsp_readback_reg  <= rsp_readback_next;
        end
    end

    // Saturating counters: hold at all-ones instead of wrapping.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign cmd_ready     = cmd_ready_reg;
    assign tgt_usr_id    = tgt_usr_id_reg;
    assign tgt_data      = tgt_data_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_applied   = rsp_applied_reg;
    assign rsp_changed   = rsp_changed_reg;
    assign rsp_violation = rsp_violation_reg;
    assign rsp_readback  = rsp_readback_reg;
    assign grant_cnt     = cnt_reg[0];
    assign deny_cnt      = cnt_reg[1];
    assign viol_cnt      = cnt_reg[2];

endmodule

// File: tb/tb_cwe1280_access_initiator.sv
// ---------------------------------------------------------------------------
// Bench for cwe1280_access_initiator. A small target register model sits on
// the tgt_* bus: it writes data_in when usr_id is PRIV_ID, or on every cycle
// when the faulty flag is set (target that grants every ID). Expected
// responses are derived from the target rule: after the settle window the
// register holds the new data if the ID was granted, otherwise its old value.
// ---------------------------------------------------------------------------
module tb_cwe1280_access_initiator;

    localparam logic [2:0] PRIV_ID = 3'h4;
    localparam logic [2:0] IDLE_ID = 3'h0;
    localparam int         SETTLE  = 2;
    localparam int         CNT_W   = 8;
    localparam int         CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_usr_id;
    logic [7:0]       cmd_data;
    logic [2:0]       tgt_usr_id;
    logic [7:0]       tgt_data;
    logic [7:0]       tgt_data_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_applied;
    logic             rsp_changed;
    logic             rsp_violation;
    logic [7:0]       rsp_readback;
    logic [CNT_W-1:0] grant_cnt;
    logic [CNT_W-1:0] deny_cnt;
    logic [CNT_W-1:0] viol_cnt;

    cwe1280_access_initiator #(
        .PRIV_ID(PRIV_ID), .IDLE_ID(IDLE_ID), .SETTLE(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_usr_id(cmd_usr_id), .cmd_data(cmd_data),
        .tgt_usr_id(tgt_usr_id), .tgt_data(tgt_data), .tgt_data_out(tgt_data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_applied(rsp_applied), .rsp_changed(rsp_changed),
        .rsp_violation(rsp_violation), .rsp_readback(rsp_readback),
        .grant_cnt(grant_cnt), .deny_cnt(deny_cnt), .viol_cnt(viol_cnt)
    );

    always #5 clk = ~clk;

    // Target register model
    logic [7:0] tgt_reg = 8'h00;
    bit         faulty  = 1'b0;
    always @(posedge clk) begin
        if (faulty || tgt_usr_id == PRIV_ID) tgt_reg <= tgt_data;
    end
    assign tgt_data_out = tgt_reg;

    int checks = 0;
    int fails  = 0;
    int exp_grant = 0, exp_deny = 0, exp_viol = 0;
    int txn = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters();
        check("grant_cnt", 32'(grant_cnt), 32'(exp_grant));
        check("deny_cnt",  32'(deny_cnt),  32'(exp_deny));
        check("viol_cnt",  32'(viol_cnt),  32'(exp_viol));
    endtask

    // One full command/response transaction. hold = cycles rsp_ready is kept
    // low once the response is up; pulse = present a second command meanwhile.
    task automatic do_cmd(input logic [2:0] id, input logic [7:0] data,
                          input int hold, input bit pulse);
        logic [7:0] pre, exp_rb;
        bit         granted, exp_app, exp_chg, exp_vio;
        int         lat;
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_usr_id = id;
        cmd_data   = data;
        pre        = tgt_reg;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("accept_cmd_ready", 32'(cmd_ready), 32'd0);
        check("accept_tgt_usr_id", 32'(tgt_usr_id), 32'(id));
        check("accept_tgt_data", 32'(tgt_data), 32'(data));

        granted = faulty || (id == PRIV_ID);
        exp_rb  = granted ? data : pre;
        exp_app = (exp_rb == data);
        exp_chg = (exp_rb != pre);
        exp_vio = (id != PRIV_ID) && exp_chg;
        if (id == PRIV_ID) begin
            if (exp_grant < CNT_MAX) exp_grant++;
        end else begin
            if (exp_deny < CNT_MAX) exp_deny++;
        end
        if (exp_vio && exp_viol < CNT_MAX) exp_viol++;

        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rsp_latency", 32'(lat), 32'(SETTLE));
        check("rsp_readback", 32'(rsp_readback), 32'(exp_rb));
        check("rsp_applied", 32'(rsp_applied), 32'(exp_app));
        check("rsp_changed", 32'(rsp_changed), 32'(exp_chg));
        check("rsp_violation", 32'(rsp_violation), 32'(exp_vio));
        check("resp_tgt_usr_id", 32'(tgt_usr_id), 32'(IDLE_ID));
        check("resp_tgt_data", 32'(tgt_data), 32'(data));
        check_counters();

        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                @(negedge clk);
                cmd_valid  = (i % 2 == 0);
                cmd_usr_id = PRIV_ID;
                cmd_data   = 8'hFF;
            end
            @(posedge clk); #1;
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_readback", 32'(rsp_readback), 32'(exp_rb));
            check("hold_flags", {29'd0, rsp_applied, rsp_changed, rsp_violation},
                  {29'd0, exp_app, exp_chg, exp_vio});
            check("hold_tgt_usr_id", 32'(tgt_usr_id), 32'(IDLE_ID));
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("done_rsp_valid", 32'(rsp_valid), 32'd0);
        check("done_cmd_ready", 32'(cmd_ready), 32'd1);
        $display("txn %0d: id=%0d data=%02h pre=%02h rb=%02h app=%0d chg=%0d vio=%0d g/d/v=%0d/%0d/%0d",
                 txn, id, data, pre, rsp_readback, rsp_applied, rsp_changed,
                 rsp_violation, grant_cnt, deny_cnt, viol_cnt);
        txn++;
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_usr_id = 3'h0;
        cmd_data   = 8'h00;
        rsp_ready  = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_tgt_usr_id", 32'(tgt_usr_id), 32'(IDLE_ID));
        check("rst_tgt_data", 32'(tgt_data), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_fields", {21'd0, rsp_applied, rsp_changed, rsp_violation, rsp_readback},
              32'd0);
        check_counters();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Privileged write, then denied write against the fixed target
        do_cmd(3'h4, 8'hA5, 0, 1'b0);
        do_cmd(3'h3, 8'h5A, 1, 1'b0);
        // rsp_ready while idle is harmless
        @(negedge clk);
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_rsp_ready_valid", 32'(rsp_valid), 32'd0);
        check("idle_rsp_ready_cmd_ready", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b0;

        // Violation through a target that grants every ID
        faulty = 1'b1;
        do_cmd(3'h1, 8'h3C, 0, 1'b0);
        faulty = 1'b0;

        // Backpressure with a second command pulsed during RESP
        do_cmd(3'h4, 8'h11, 5, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            check("no_second_capture_rsp", 32'(rsp_valid), 32'd0);
            check("no_second_capture_id", 32'(tgt_usr_id), 32'(IDLE_ID));
        end

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            faulty = 1'($urandom_range(0, 1));
            do_cmd(3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 3), 1'b0);
        end
        faulty = 1'b0;

        // Saturation of grant_cnt
        for (int n = 0; n < 260; n++) do_cmd(PRIV_ID, 8'($urandom), 0, 1'b0);
        check("grant_saturated", 32'(grant_cnt), 32'(CNT_MAX));

        // Asynchronous reset in the middle of DRIVE
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_usr_id = PRIV_ID;
        cmd_data   = 8'hC3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("pre_abort_tgt_usr_id", 32'(tgt_usr_id), 32'(PRIV_ID));
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_grant = 0; exp_deny = 0; exp_viol = 0;
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_tgt_usr_id", 32'(tgt_usr_id), 32'(IDLE_ID));
        check("abort_tgt_data", 32'(tgt_data), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check_counters();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("post_abort_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        do_cmd(PRIV_ID, 8'h77, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
